muxnx1_scan: RTL and testbench

- Parametrised, registered N:1 multiplexer; successor to the 2:1 switch-level mux.
- Generalised to CHANNELS inputs of WIDTH bits.
- Adds a manual-select mode, an auto-scan mode that sequences through channels with a programmable dwell, and a valid/ready output handshake with backpressure.
- Used as the channel sequencer ahead of shared downstream logic in the liyamin datapath blocks.

---
 rtl/muxnx1_scan_if.sv | 18 +
 rtl/muxnx1_scan.sv | 58 +++++
 tb/tb_muxnx1_scan.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muxnx1_scan_if.sv
// muxnx1_scan_if: control, data and valid/ready output bundle of the N:1 scan mux
interface muxnx1_scan_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) ();
  logic                      mode;
  logic                      en;
  logic [SEL_W-1:0]          s;
  logic [CHANNELS*WIDTH-1:0] a;
  logic                      ready;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          y_sel;
  logic                      y_valid;
  logic                      sel_err;
  modport master (output mode, en, s, a, ready, input y, y_sel, y_valid, sel_err);
  modport slave  (input mode, en, s, a, ready, output y, y_sel, y_valid, sel_err);
endinterface

// File: rtl/muxnx1_scan.sv
// muxnx1_scan: registered N:1 mux with manual select, dwell-based auto-scan and valid/ready output
module muxnx1_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input logic           clk,
  input logic           rst_n,
  muxnx1_scan_if.slave  bus
);
  logic [WIDTH-1:0] y_q, y_d, data;
  logic [SEL_W-1:0] sel_q, sel_d, ch_q, ch_d, cur;
  logic [7:0]       dc_q, dc_d;
  logic             v_q, v_d, err_q, err_d, m_q;
  logic             cap, entry, bad, adv, last;
  always_comb begin
    cap   = bus.en && (!v_q || bus.ready);
    entry = bus.mode && !m_q;
    // a scan entry captures from channel 0 even before the pointer register is cleared
    cur   = bus.mode ? (entry ? '0 : ch_q) : bus.s;
    bad   = !bus.mode && (32'(bus.s) >= CHANNELS);
    data  = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (cur == SEL_W'(k)) data = bus.a[k*WIDTH +: WIDTH];
    adv   = cap && bus.mode && !entry;
    last  = dc_q == 8'(DWELL - 1);
    y_d   = cap ? data : y_q;
    sel_d = cap ? cur : sel_q;
    err_d = cap ? bad : err_q;
    v_d   = cap || (v_q && !bus.ready);
    ch_d  = entry ? '0 : (adv && last) ? ((ch_q == SEL_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1) : ch_q;
    dc_d  = entry ? '0 : adv ? (last ? '0 : dc_q + 8'd1) : dc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      sel_q <= '0;
      v_q   <= 1'b0;
      err_q <= 1'b0;
      ch_q  <= '0;
      dc_q  <= '0;
      m_q   <= 1'b0;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
      v_q   <= v_d;
      err_q <= err_d;
      ch_q  <= ch_d;
      dc_q  <= dc_d;
      m_q   <= bus.mode;
    end
  end
  assign bus.y       = y_q;
  assign bus.y_sel   = sel_q;
  assign bus.y_valid = v_q;
  assign bus.sel_err = err_q;
endmodule

// File: tb/tb_muxnx1_scan.sv
// tb_muxnx1_scan: scenario tasks plus a randomized run against a behavioural model
module tb_muxnx1_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  muxnx1_scan_if #(.WIDTH(1), .CHANNELS(2), .SEL_W(1)) ifa ();
  muxnx1_scan_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) ifb ();
  muxnx1_scan_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) ifc ();
  muxnx1_scan #(.WIDTH(1), .CHANNELS(2), .SEL_W(1), .DWELL(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  muxnx1_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  muxnx1_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {ifa.mode, ifa.en, ifa.s, ifa.a, ifa.ready} = '0;
    {ifb.mode, ifb.en, ifb.s, ifb.a, ifb.ready} = '0;
    {ifc.mode, ifc.en, ifc.s, ifc.a, ifc.ready} = '0;
    rst_n = 1'b0;
    step();
    total++;
    if ({ifb.y, ifb.y_sel, ifb.y_valid, ifb.sel_err} !== 12'h0) begin
      bad++;
      $display("FAIL reset_b got=%h want=0", {ifb.y, ifb.y_sel, ifb.y_valid, ifb.sel_err});
    end
    total++;
    if ({ifa.y, ifa.y_sel, ifa.y_valid, ifa.sel_err, ifc.y_valid, ifc.sel_err} !== 6'h0) begin
      bad++;
      $display("FAIL reset_ac got=%b want=0", {ifa.y, ifa.y_sel, ifa.y_valid, ifa.sel_err, ifc.y_valid, ifc.sel_err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    ifa.mode = 1'b0;
    ifa.en = 1'b1;
    ifa.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      ifa.s = v[2];
      ifa.a = v[1:0];
      step();
      total++;
      if ({ifa.y, ifa.y_valid, ifa.sel_err} !== {v[v[2]], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL truth s=%0d a=%b got y/v/e=%b want=%b", v[2], v[1:0], {ifa.y, ifa.y_valid, ifa.sel_err}, {v[v[2]], 2'b10});
      end
    end
    ifa.en = 1'b0;
  endtask

  task automatic test_manual();
    ifb.mode = 1'b0;
    ifb.a = {8'h44, 8'h33, 8'h22, 8'h11};
    ifb.s = 2'd2;
    ifb.en = 1'b1;
    ifb.ready = 1'b1;
    step();
    total++;
    if ({ifb.y, ifb.y_sel, ifb.y_valid} !== {8'h33, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL manual_cap got y=%h sel=%0d v=%b want y=33 sel=2 v=1", ifb.y, ifb.y_sel, ifb.y_valid);
    end
    ifb.en = 1'b0;
    step();
    total++;
    if ({ifb.y, ifb.y_valid} !== {8'h33, 1'b0}) begin
      bad++;
      $display("FAIL manual_drain got y=%h v=%b want y=33 v=0", ifb.y, ifb.y_valid);
    end
  endtask

  task automatic test_scan();
    int exp_sel [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    logic [31:0] av = {8'h44, 8'h33, 8'h22, 8'h11};
    ifb.a = av;
    ifb.mode = 1'b1;
    ifb.en = 1'b0;
    ifb.ready = 1'b1;
    step();
    ifb.en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 9) begin
        ifb.en = 1'b0;
        step();
        step();
        total++;
        if (ifb.y_valid !== 1'b0) begin
          bad++;
          $display("FAIL scan_stall_valid got=%b want=0", ifb.y_valid);
        end
        ifb.en = 1'b1;
      end
      step();
      total++;
      if ({ifb.y, ifb.y_sel, ifb.y_valid} !== {av[8*exp_sel[i] +: 8], 2'(exp_sel[i]), 1'b1}) begin
        bad++;
        $display("FAIL scan_seq[%0d] got y=%h sel=%0d v=%b want y=%h sel=%0d v=1", i, ifb.y, ifb.y_sel, ifb.y_valid, av[8*exp_sel[i] +: 8], exp_sel[i]);
      end
    end
    ifb.en = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    ifc.a = {8'hC3, 8'hB2, 8'hA1};
    ifc.mode = 1'b1;
    ifc.en = 1'b0;
    ifc.ready = 1'b1;
    step();
    ifc.en = 1'b1;
    step();
    total++;
    if ({ifc.y, ifc.y_sel, ifc.y_valid} !== {8'hA1, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL bp_first got y=%h sel=%0d v=%b want y=a1 sel=0 v=1", ifc.y, ifc.y_sel, ifc.y_valid);
    end
    ifc.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifc.a = {8'h5A, 8'h5A, 8'h5A};
      step();
      total++;
      if ({ifc.y, ifc.y_sel, ifc.y_valid} !== {8'hA1, 2'd0, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got y=%h sel=%0d v=%b want y=a1 sel=0 v=1", i, ifc.y, ifc.y_sel, ifc.y_valid);
      end
    end
    ifc.a = {8'hC3, 8'hB2, 8'hA1};
    ifc.ready = 1'b1;
    step();
    total++;
    if ({ifc.y, ifc.y_sel, ifc.y_valid} !== {8'hB2, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL bp_next1 got y=%h sel=%0d v=%b want y=b2 sel=1 v=1", ifc.y, ifc.y_sel, ifc.y_valid);
    end
    step();
    total++;
    if ({ifc.y, ifc.y_sel, ifc.y_valid} !== {8'hC3, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL bp_next2 got y=%h sel=%0d v=%b want y=c3 sel=2 v=1", ifc.y, ifc.y_sel, ifc.y_valid);
    end
    ifc.en = 1'b0;
  endtask

  task automatic test_invalid_sel();
    ifc.mode = 1'b0;
    ifc.s = 2'd3;
    ifc.en = 1'b1;
    ifc.ready = 1'b1;
    step();
    total++;
    if ({ifc.y, ifc.y_sel, ifc.sel_err, ifc.y_valid} !== {8'h00, 2'd3, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL invalid_sel got y=%h sel=%0d err=%b v=%b want y=0 sel=3 err=1 v=1", ifc.y, ifc.y_sel, ifc.sel_err, ifc.y_valid);
    end
    ifc.s = 2'd1;
    step();
    total++;
    if ({ifc.y, ifc.y_sel, ifc.sel_err} !== {8'hB2, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL invalid_clear got y=%h sel=%0d err=%b want y=b2 sel=1 err=0", ifc.y, ifc.y_sel, ifc.sel_err);
    end
    ifc.en = 1'b0;
  endtask

  task automatic test_async_reset();
    ifb.a = {8'h44, 8'h33, 8'h22, 8'h11};
    ifb.mode = 1'b0;
    ifb.en = 1'b0;
    ifb.ready = 1'b1;
    step();
    ifb.mode = 1'b1;
    step();
    ifb.en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ifb.en = 1'b0;
    ifb.ready = 1'b0;
    total++;
    if ({ifb.y, ifb.y_sel, ifb.y_valid} !== {8'h22, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL areset_pre got y=%h sel=%0d v=%b want y=22 sel=1 v=1", ifb.y, ifb.y_sel, ifb.y_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ifb.y, ifb.y_sel, ifb.y_valid, ifb.sel_err} !== 12'h0) begin
      bad++;
      $display("FAIL areset_immediate got=%h want=0", {ifb.y, ifb.y_sel, ifb.y_valid, ifb.sel_err});
    end
    step();
    rst_n = 1'b1;
    ifb.en = 1'b1;
    ifb.ready = 1'b1;
    step();
    total++;
    if ({ifb.y, ifb.y_sel, ifb.y_valid} !== {8'h11, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL areset_after got y=%h sel=%0d v=%b want y=11 sel=0 v=1", ifb.y, ifb.y_sel, ifb.y_valid);
    end
    ifb.en = 1'b0;
  endtask

  task automatic test_random();
    int ch = 0, dc = 0, msel = 0;
    bit mm = 0, mv = 0, merr = 0, take;
    logic [7:0] my = '0;
    logic [31:0] av;
    int nbad = 0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0) ifb.mode = ~ifb.mode;
      ifb.en = ($urandom_range(0, 3) != 0);
      ifb.ready = ($urandom_range(0, 2) != 0);
      ifb.s = 2'($urandom_range(0, 3));
      av = $urandom;
      ifb.a = av;
      step();
      take = ifb.en && (!mv || ifb.ready);
      if (ifb.mode && !mm) begin
        ch = 0;
        dc = 0;
        if (take) begin
          my = av[8*0 +: 8];
          msel = 0;
          merr = 0;
        end
      end else if (take && ifb.mode) begin
        my = av[8*ch +: 8];
        msel = ch;
        merr = 0;
        dc = dc + 1;
        if (dc == 2) begin
          dc = 0;
          ch = (ch + 1) % 4;
        end
      end else if (take) begin
        my = av[8*ifb.s +: 8];
        msel = ifb.s;
        merr = 0;
      end
      mv = take || (mv && !ifb.ready);
      mm = ifb.mode;
      total++;
      if ({ifb.y, ifb.y_sel, ifb.y_valid, ifb.sel_err} !== {my, 2'(msel), mv, merr}) begin
        bad++;
        nbad++;
        if (nbad < 10)
          $display("FAIL random[%0d] got y=%h sel=%0d v=%b e=%b want y=%h sel=%0d v=%b e=%b", i, ifb.y, ifb.y_sel, ifb.y_valid, ifb.sel_err, my, msel, mv, merr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_manual();
    test_scan();
    test_back_to_back();
    test_invalid_sel();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
